intc_vectored: RTL and testbench

- Parametrised successor to the single-line interrupt input of the multi-cycle MIPS top.
- Collects NUM_IRQ maskable interrupt sources plus one non-maskable source.
- Latches pending events, applies a software-written enable mask and fixed priority, and presents one vectored request to the CPU control FSM with a req/ack/EOI handshake.
- Supports one level of nesting: NMI may preempt a maskable handler in service.

---
 rtl/intc_pkg.sv | 16 +
 rtl/intc_vectored_if.sv | 27 ++
 rtl/intc_prio_enc.sv | 23 ++
 rtl/intc_vectored.sv | 140 ++++++++++++++
 tb/tb_intc_vectored.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REQ         = 2'd1,
        SERVICE     = 2'd2,
        NMI_SERVICE = 2'd3
    } intc_state_t;

    // The NMI is reported as the vector one past the last maskable source.
    function automatic int nmi_vec(input int num_irq);
        return num_irq;
    endfunction

endpackage

// File: rtl/intc_vectored_if.sv
// CPU-facing bus of the interrupt controller: mask register access and the
// req/ack/EOI handshake.
interface intc_vectored_if #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 5
);
    logic               cpu_busy;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic               irq_req;
    logic [VEC_W-1:0]   irq_vector;
    logic               irq_ack;
    logic               irq_eoi;
    logic               in_service;

    modport master (
        output cpu_busy, mask_we, mask_wdata, irq_ack, irq_eoi,
        input  mask_q, pending_q, irq_req, irq_vector, in_service
    );

    modport slave (
        input  cpu_busy, mask_we, mask_wdata, irq_ack, irq_eoi,
        output mask_q, pending_q, irq_req, irq_vector, in_service
    );
endinterface

// File: rtl/intc_prio_enc.sv
// Combinational fixed-priority encoder: lowest set index wins.
module intc_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 5
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [VEC_W-1:0]   idx,
    output logic               valid
);

    // Scanning downwards lets the lowest asserted index overwrite the rest.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = VEC_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intc_vectored.sv
// Vectored interrupt controller: NUM_IRQ maskable sources plus one NMI,
// fixed priority, req/ack/EOI handshake with one level of NMI nesting.
module intc_vectored
    import intc_pkg::*;
#(
    parameter int                 NUM_IRQ   = 8,
    parameter int                 VEC_W     = 5,
    parameter logic [NUM_IRQ-1:0] EDGE_MODE = {NUM_IRQ{1'b1}}
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               nmi_in,
    intc_vectored_if.slave     bus
);

    localparam logic [VEC_W-1:0] NMI_V = VEC_W'(nmi_vec(NUM_IRQ));

    intc_state_t        state;
    logic [NUM_IRQ-1:0] mask_r;
    logic [NUM_IRQ-1:0] pending_r;
    logic [NUM_IRQ-1:0] prev_r;
    logic               nmi_pending;
    logic               nmi_prev;
    logic               nested;
    logic               req_r;
    logic [VEC_W-1:0]   vector_r;
    logic [VEC_W-1:0]   saved_vec;

    logic               ack_fire;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] pending_n;
    logic               nmi_pending_n;
    logic [VEC_W-1:0]   cand_idx;
    logic               cand_valid;

    assign ack_fire = (state == REQ) && bus.irq_ack;

    // Edge channels latch rising edges and clear on ack, with a new edge on
    // the ack cycle winning; level channels simply follow the source.
    always_comb begin
        clr       = '0;
        pending_n = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = ack_fire && (vector_r == VEC_W'(i));
            if (EDGE_MODE[i])
                pending_n[i] = (irq_in[i] & ~prev_r[i]) | (pending_r[i] & ~clr[i]);
            else
                pending_n[i] = irq_in[i];
        end
        nmi_pending_n = (nmi_in & ~nmi_prev) |
                        (nmi_pending & ~(ack_fire && (vector_r == NMI_V)));
    end

    intc_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .VEC_W   (VEC_W)
    ) u_prio_enc (
        .req   (pending_r & mask_r),
        .idx   (cand_idx),
        .valid (cand_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_r      <= '0;
            pending_r   <= '0;
            prev_r      <= '0;
            nmi_pending <= 1'b0;
            nmi_prev    <= 1'b0;
        end else begin
            prev_r      <= irq_in;
            nmi_prev    <= nmi_in;
            pending_r   <= pending_n;
            nmi_pending <= nmi_pending_n;
            if (bus.mask_we)
                mask_r <= bus.mask_wdata;
        end
    end

    // Handshake FSM; ack takes precedence over everything else while in REQ.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_r     <= 1'b0;
            vector_r  <= '0;
            saved_vec <= '0;
            nested    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.cpu_busy && (nmi_pending || cand_valid)) begin
                        state    <= REQ;
                        req_r    <= 1'b1;
                        vector_r <= nmi_pending ? NMI_V : cand_idx;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        req_r <= 1'b0;
                        state <= (vector_r == NMI_V) ? NMI_SERVICE : SERVICE;
                    end else if (nmi_pending) begin
                        vector_r <= NMI_V;
                    end
                end
                SERVICE: begin
                    if (bus.irq_eoi) begin
                        state <= IDLE;
                    end else if (nmi_pending && !bus.cpu_busy) begin
                        nested    <= 1'b1;
                        saved_vec <= vector_r;
                        vector_r  <= NMI_V;
                        req_r     <= 1'b1;
                        state     <= REQ;
                    end
                end
                NMI_SERVICE: begin
                    if (bus.irq_eoi) begin
                        if (nested) begin
                            nested   <= 1'b0;
                            vector_r <= saved_vec;
                            state    <= SERVICE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mask_q     = mask_r;
    assign bus.pending_q  = pending_r;
    assign bus.irq_req    = req_r;
    assign bus.irq_vector = vector_r;
    assign bus.in_service = (state == SERVICE) || (state == NMI_SERVICE) ||
                            ((state == REQ) && nested);

endmodule

// File: tb/tb_intc_vectored.sv
// Directed self-checking bench for intc_vectored; channel 6 is level-triggered.
module tb_intc_vectored;

    logic       clock;
    logic       reset_n;
    logic [7:0] irq_in;
    logic       nmi_in;
    int         errors;
    int         checks;

    intc_vectored_if #(.NUM_IRQ(8), .VEC_W(5)) bus ();

    intc_vectored #(
        .NUM_IRQ   (8),
        .VEC_W     (5),
        .EDGE_MODE (8'hBF)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .irq_in  (irq_in),
        .nmi_in  (nmi_in),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle just after the last one.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        irq_in = '0;
        nmi_in = 1'b0;
        bus.cpu_busy = 1'b0;
        bus.mask_we = 1'b0;
        bus.mask_wdata = '0;
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b0;
        cyc(2);
        checks++; if (bus.mask_q !== 8'h00) begin errors++; $display("[TB] FAIL reset_mask got=%h exp=00", bus.mask_q); end
        checks++; if (bus.pending_q !== 8'h00) begin errors++; $display("[TB] FAIL reset_pending got=%h exp=00", bus.pending_q); end
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b exp=0", bus.irq_req); end
        checks++; if (bus.irq_vector !== 5'd0) begin errors++; $display("[TB] FAIL reset_vector got=%0d exp=0", bus.irq_vector); end
        checks++; if (bus.in_service !== 1'b0) begin errors++; $display("[TB] FAIL reset_inserv got=%b exp=0", bus.in_service); end
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_mask_gating;
        irq_in[3] = 1'b1;
        cyc(1);
        checks++; if (bus.pending_q !== 8'h08) begin errors++; $display("[TB] FAIL mask_pending got=%h exp=08", bus.pending_q); end
        irq_in[3] = 1'b0;
        cyc(1);
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL mask_noreq got=%b exp=0", bus.irq_req); end
        bus.mask_we = 1'b1;
        bus.mask_wdata = 8'hFF;
        cyc(1);
        bus.mask_we = 1'b0;
        checks++; if (bus.mask_q !== 8'hFF) begin errors++; $display("[TB] FAIL mask_write got=%h exp=FF", bus.mask_q); end
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL mask_req_early got=%b exp=0", bus.irq_req); end
        cyc(1);
        checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("[TB] FAIL mask_req got=%b exp=1", bus.irq_req); end
        checks++; if (bus.irq_vector !== 5'd3) begin errors++; $display("[TB] FAIL mask_vector got=%0d exp=3", bus.irq_vector); end
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL mask_ack_req got=%b exp=0", bus.irq_req); end
        checks++; if (bus.pending_q !== 8'h00) begin errors++; $display("[TB] FAIL mask_ack_clr got=%h exp=00", bus.pending_q); end
        checks++; if (bus.in_service !== 1'b1) begin errors++; $display("[TB] FAIL mask_inserv got=%b exp=1", bus.in_service); end
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
        checks++; if (bus.in_service !== 1'b0) begin errors++; $display("[TB] FAIL mask_eoi got=%b exp=0", bus.in_service); end
    endtask

    task automatic test_priority;
        irq_in[5] = 1'b1;
        irq_in[2] = 1'b1;
        cyc(1);
        irq_in[5] = 1'b0;
        irq_in[2] = 1'b0;
        checks++; if (bus.pending_q !== 8'h24) begin errors++; $display("[TB] FAIL prio_pending got=%h exp=24", bus.pending_q); end
        cyc(1);
        checks++; if (bus.irq_vector !== 5'd2 || bus.irq_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_first got=%0d/%b exp=2/1", bus.irq_vector, bus.irq_req); end
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        checks++; if (bus.pending_q !== 8'h20) begin errors++; $display("[TB] FAIL prio_after_ack got=%h exp=20", bus.pending_q); end
        cyc(1);
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_service_block got=%b exp=0", bus.irq_req); end
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_eoi_gap got=%b exp=0", bus.irq_req); end
        cyc(1);
        checks++; if (bus.irq_vector !== 5'd5 || bus.irq_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_second got=%0d/%b exp=5/1", bus.irq_vector, bus.irq_req); end
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
    endtask

    task automatic test_busy;
        bus.cpu_busy = 1'b1;
        irq_in[0] = 1'b1;
        cyc(1);
        irq_in[0] = 1'b0;
        cyc(2);
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL busy_block got=%b exp=0", bus.irq_req); end
        bus.cpu_busy = 1'b0;
        cyc(1);
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_vector !== 5'd0) begin errors++; $display("[TB] FAIL busy_release got=%b/%0d exp=1/0", bus.irq_req, bus.irq_vector); end
        bus.cpu_busy = 1'b1;
        bus.mask_we = 1'b1;
        bus.mask_wdata = 8'hFE;
        cyc(2);
        bus.mask_we = 1'b0;
        checks++; if (bus.irq_req !== 1'b1 || bus.irq_vector !== 5'd0) begin errors++; $display("[TB] FAIL busy_hold got=%b/%0d exp=1/0", bus.irq_req, bus.irq_vector); end
        bus.cpu_busy = 1'b0;
        bus.mask_we = 1'b1;
        bus.mask_wdata = 8'hFF;
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.mask_we = 1'b0;
        bus.irq_ack = 1'b0;
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL busy_ack got=%b exp=0", bus.irq_req); end
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
    endtask

    task automatic test_nested_nmi;
        irq_in[4] = 1'b1;
        cyc(1);
        irq_in[4] = 1'b0;
        cyc(1);
        checks++; if (bus.irq_vector !== 5'd4 || bus.irq_req !== 1'b1) begin errors++; $display("[TB] FAIL nest_req4 got=%0d/%b exp=4/1", bus.irq_vector, bus.irq_req); end
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        nmi_in = 1'b1;
        cyc(1);
        nmi_in = 1'b0;
        cyc(1);
        checks++; if (bus.irq_vector !== 5'd8 || bus.irq_req !== 1'b1) begin errors++; $display("[TB] FAIL nest_nmi_req got=%0d/%b exp=8/1", bus.irq_vector, bus.irq_req); end
        checks++; if (bus.in_service !== 1'b1) begin errors++; $display("[TB] FAIL nest_inserv_req got=%b exp=1", bus.in_service); end
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        checks++; if (bus.irq_req !== 1'b0 || bus.in_service !== 1'b1) begin errors++; $display("[TB] FAIL nest_nmi_serv got=%b/%b exp=0/1", bus.irq_req, bus.in_service); end
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
        checks++; if (bus.in_service !== 1'b1 || bus.irq_vector !== 5'd4) begin errors++; $display("[TB] FAIL nest_restore got=%b/%0d exp=1/4", bus.in_service, bus.irq_vector); end
        cyc(1);
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL nest_no_rereq got=%b exp=0", bus.irq_req); end
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
        checks++; if (bus.in_service !== 1'b0) begin errors++; $display("[TB] FAIL nest_done got=%b exp=0", bus.in_service); end
    endtask

    task automatic test_level_and_set_wins;
        irq_in[6] = 1'b1;
        cyc(2);
        checks++; if (bus.irq_vector !== 5'd6 || bus.irq_req !== 1'b1) begin errors++; $display("[TB] FAIL level_req got=%0d/%b exp=6/1", bus.irq_vector, bus.irq_req); end
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        checks++; if (bus.pending_q !== 8'h40) begin errors++; $display("[TB] FAIL level_ack_keep got=%h exp=40", bus.pending_q); end
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
        cyc(1);
        checks++; if (bus.irq_vector !== 5'd6 || bus.irq_req !== 1'b1) begin errors++; $display("[TB] FAIL level_rereq got=%0d/%b exp=6/1", bus.irq_vector, bus.irq_req); end
        irq_in[6] = 1'b0;
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        checks++; if (bus.pending_q !== 8'h00) begin errors++; $display("[TB] FAIL level_drop got=%h exp=00", bus.pending_q); end
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
        irq_in[1] = 1'b1;
        cyc(1);
        irq_in[1] = 1'b0;
        cyc(1);
        checks++; if (bus.irq_vector !== 5'd1 || bus.irq_req !== 1'b1) begin errors++; $display("[TB] FAIL setwin_req got=%0d/%b exp=1/1", bus.irq_vector, bus.irq_req); end
        bus.irq_ack = 1'b1;
        irq_in[1] = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        irq_in[1] = 1'b0;
        checks++; if (bus.pending_q !== 8'h02 || bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL setwin_keep got=%h/%b exp=02/0", bus.pending_q, bus.irq_req); end
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
        cyc(1);
        checks++; if (bus.irq_vector !== 5'd1 || bus.irq_req !== 1'b1) begin errors++; $display("[TB] FAIL setwin_rereq got=%0d/%b exp=1/1", bus.irq_vector, bus.irq_req); end
        bus.irq_ack = 1'b1;
        cyc(1);
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b1;
        cyc(1);
        bus.irq_eoi = 1'b0;
    endtask

    task automatic test_reset_mid_handshake;
        irq_in[2] = 1'b1;
        cyc(1);
        irq_in[2] = 1'b0;
        irq_in[7] = 1'b1;
        cyc(1);
        irq_in[7] = 1'b0;
        checks++; if (bus.irq_req !== 1'b1 || bus.pending_q !== 8'h84) begin errors++; $display("[TB] FAIL rst_pre got=%b/%h exp=1/84", bus.irq_req, bus.pending_q); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_req got=%b exp=0", bus.irq_req); end
        checks++; if (bus.in_service !== 1'b0 || bus.pending_q !== 8'h00) begin errors++; $display("[TB] FAIL rst_async_state got=%b/%h exp=0/00", bus.in_service, bus.pending_q); end
        checks++; if (bus.mask_q !== 8'h00) begin errors++; $display("[TB] FAIL rst_async_mask got=%h exp=00", bus.mask_q); end
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_after got=%b exp=0", bus.irq_req); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mask_gating();
        test_priority();
        test_busy();
        test_nested_nmi();
        test_level_and_set_wins();
        test_reset_mid_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
